// File: rtl/mem_arb_pkg.sv
// Shared encodings and default widths for the IFU/LSU memory-port arbiter.
// Holds no logic beyond a saturating-increment helper for the LSU streak counter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF         = 32;
  localparam int DATA_W_DEF         = 32;
  localparam int MAX_LSU_STREAK_DEF = 4;
  localparam int STREAK_W           = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IFU  = 2'd1,
    OWN_LSU  = 2'd2
  } owner_t;

  function automatic logic [STREAK_W-1:0] sat_inc(input logic [STREAK_W-1:0] v);
    return (v == {STREAK_W{1'b1}}) ? v : v + STREAK_W'(1);
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Grant selection: LSU wins ties until it has taken MAX_LSU_STREAK grants while the IFU waited.
// Zero-latency combinational grant gated by i_idle; only the streak counter is registered.
module mem_arb_grant
  import mem_arb_pkg::*;
#(
  parameter int MAX_LSU_STREAK = MAX_LSU_STREAK_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_idle,
  input  logic i_ifu_vld,
  input  logic i_lsu_vld,
  output logic o_grant_ifu,
  output logic o_grant_lsu
);

  logic [STREAK_W-1:0] r_streak;
  logic                w_ifu_turn;

  always_comb begin
    w_ifu_turn  = (r_streak == STREAK_W'(MAX_LSU_STREAK));
    o_grant_lsu = i_idle & i_lsu_vld & ~(i_ifu_vld & w_ifu_turn);
    o_grant_ifu = i_idle & i_ifu_vld & (~i_lsu_vld | w_ifu_turn);
  end

  // Streak only grows while the IFU is actually being held off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_streak <= '0;
    end else if (o_grant_lsu) begin
      r_streak <= i_ifu_vld ? sat_inc(r_streak) : '0;
    end else if (o_grant_ifu) begin
      r_streak <= '0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU (read-only) and LSU; one transaction in flight.
// Grant to mem_req_valid 1 cycle, response passed through combinationally; stalls on mem/owner ready.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int MAX_LSU_STREAK = MAX_LSU_STREAK_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rsp_data,
  input  logic                ifu_rsp_ready,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rsp_data,
  input  logic                lsu_rsp_ready,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data,
  output logic                mem_rsp_ready,
  output logic                arb_busy
);

  localparam int MASK_W = DATA_W / 8;

  state_t              r_state;
  state_t              w_next_state;
  owner_t              r_owner;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wen;
  logic [DATA_W-1:0]   r_wdata;
  logic [MASK_W-1:0]   r_wmask;

  logic                w_idle;
  logic                w_grant_ifu;
  logic                w_grant_lsu;
  logic                w_owner_rsp_ready;
  logic                w_rsp_done;

  // Grant depends only on state and requester valids, never on downstream handshakes.
  assign w_idle = (r_state == ST_IDLE) & ~rst;

  mem_arb_grant #(
    .MAX_LSU_STREAK (MAX_LSU_STREAK)
  ) u_grant (
    .clk         (clk),
    .rst         (rst),
    .i_idle      (w_idle),
    .i_ifu_vld   (ifu_req_valid),
    .i_lsu_vld   (lsu_req_valid),
    .o_grant_ifu (w_grant_ifu),
    .o_grant_lsu (w_grant_lsu)
  );

  always_comb begin
    w_owner_rsp_ready = 1'b0;
    case (r_owner)
      OWN_IFU: w_owner_rsp_ready = ifu_rsp_ready;
      OWN_LSU: w_owner_rsp_ready = lsu_rsp_ready;
      default: w_owner_rsp_ready = 1'b0;
    endcase
    w_rsp_done = (r_state == ST_RSP) & mem_rsp_valid & w_owner_rsp_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_grant_ifu | w_grant_lsu) w_next_state = ST_REQ;
      ST_REQ:  if (mem_req_ready)             w_next_state = ST_RSP;
      ST_RSP:  if (w_rsp_done)                w_next_state = ST_IDLE;
      default:                                w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner <= OWN_NONE;
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else if (w_grant_lsu) begin
      r_owner <= OWN_LSU;
      r_addr  <= lsu_req_addr;
      r_wen   <= lsu_req_wen;
      r_wdata <= lsu_req_wdata;
      r_wmask <= lsu_req_wmask;
    end else if (w_grant_ifu) begin
      r_owner <= OWN_IFU;
      r_addr  <= ifu_req_addr;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else if (w_rsp_done) begin
      r_owner <= OWN_NONE;
    end
  end

  always_comb begin
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_rsp_data  = '0;
    lsu_rsp_valid = 1'b0;
    lsu_rsp_data  = '0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    mem_req_wen   = 1'b0;
    mem_req_wdata = '0;
    mem_req_wmask = '0;
    mem_rsp_ready = 1'b0;
    arb_busy      = 1'b0;
    if (!rst) begin
      ifu_req_ready = w_grant_ifu;
      lsu_req_ready = w_grant_lsu;
      arb_busy      = (r_state != ST_IDLE);
      mem_req_addr  = r_addr;
      mem_req_wen   = r_wen;
      mem_req_wdata = r_wdata;
      mem_req_wmask = r_wmask;
      case (r_state)
        ST_REQ: mem_req_valid = 1'b1;
        ST_RSP: begin
          mem_rsp_ready = w_owner_rsp_ready;
          if (r_owner == OWN_IFU) begin
            ifu_rsp_valid = mem_rsp_valid;
            ifu_rsp_data  = mem_rsp_data;
          end else if (r_owner == OWN_LSU) begin
            lsu_rsp_valid = mem_rsp_valid;
            lsu_rsp_data  = mem_rsp_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, IFU read, LSU write with stalls, priority,
// starvation streak and response backpressure, each with hand-computed expectations.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
  logic [31:0] ifu_req_addr, ifu_rsp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid, lsu_rsp_ready;
  logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_data;
  logic [3:0]  lsu_req_wmask;
  logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid, mem_rsp_ready;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_data;
  logic [3:0]  mem_req_wmask;
  logic        arb_busy;
  logic [139:0] all_outs;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign all_outs = {ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, lsu_req_ready, lsu_rsp_valid,
                     lsu_rsp_data, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata,
                     mem_req_wmask, mem_rsp_ready, arb_busy};

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_ready(ifu_rsp_ready),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_ready(lsu_rsp_ready),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_ready(mem_rsp_ready),
    .arb_busy(arb_busy)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h0; ifu_rsp_ready = 1'b0;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h0; lsu_req_wen = 1'b0;
    lsu_req_wdata = 32'h0; lsu_req_wmask = 4'h0; lsu_rsp_ready = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
    #2;
    vectors++;
    if (all_outs !== '0) begin
      miscompares++; $display("FAIL reset_outputs_zero: got %h expected 0", all_outs);
    end
    step; step;
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; rst = 1'b0;
    #2;
    vectors++;
    if (all_outs !== '0) begin
      miscompares++; $display("FAIL release_idle: got %h expected 0", all_outs);
    end
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h0000_1000;
    #2;
    vectors++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin
      miscompares++; $display("FAIL rst_grant: got %b expected 01", {ifu_req_ready, lsu_req_ready});
    end
    step;
    lsu_req_valid = 1'b0;
    #2;
    vectors++;
    if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h0000_1000}) begin
      miscompares++; $display("FAIL rst_in_req: got %h expected 100001000", {mem_req_valid, mem_req_addr});
    end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({mem_req_valid, arb_busy, mem_req_addr} !== '0) begin
      miscompares++; $display("FAIL rst_async_drop: got %h expected 0", {mem_req_valid, arb_busy, mem_req_addr});
    end
    step;
    rst = 1'b0;
    #2;
    vectors++;
    if ({mem_req_valid, arb_busy} !== 2'b00) begin
      miscompares++; $display("FAIL rst_back_idle: got %b expected 00", {mem_req_valid, arb_busy});
    end
  endtask

  task automatic test_ifu_read;
    step;
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000; ifu_rsp_ready = 1'b1;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0413;
    #2;
    vectors++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
      miscompares++; $display("FAIL ifu_grant: got %b expected 10", {ifu_req_ready, lsu_req_ready});
    end
    step;
    ifu_req_valid = 1'b0; ifu_req_addr = 32'h1234_5678;
    #2;
    vectors++;
    if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask} !==
        {1'b1, 32'h8000_0000, 1'b0, 32'h0, 4'h0}) begin
      miscompares++;
      $display("FAIL ifu_req_fields: got %h expected %h",
               {mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask},
               {1'b1, 32'h8000_0000, 1'b0, 32'h0, 4'h0});
    end
    step;
    #2;
    vectors++;
    if ({ifu_rsp_valid, ifu_rsp_data, lsu_rsp_valid, mem_rsp_ready} !== {1'b1, 32'h0000_0413, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL ifu_rsp: got %h expected %h", {ifu_rsp_valid, ifu_rsp_data, lsu_rsp_valid, mem_rsp_ready},
               {1'b1, 32'h0000_0413, 1'b0, 1'b1});
    end
    step;
    mem_rsp_valid = 1'b0; mem_req_ready = 1'b0;
    #2;
    vectors++;
    if ({arb_busy, ifu_rsp_valid} !== 2'b00) begin
      miscompares++; $display("FAIL ifu_done: got %b expected 00", {arb_busy, ifu_rsp_valid});
    end
  endtask

  task automatic test_lsu_write;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_1000; lsu_req_wen = 1'b1;
    lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 4'hF; lsu_rsp_ready = 1'b1;
    #2;
    vectors++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin
      miscompares++; $display("FAIL lsu_grant: got %b expected 01", {ifu_req_ready, lsu_req_ready});
    end
    step;
    lsu_req_valid = 1'b0; lsu_req_addr = 32'hFFFF_FFFF; lsu_req_wdata = 32'h0; lsu_req_wmask = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_req_ready = 1'b1;
      #2;
      vectors++;
      if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask, ifu_rsp_valid} !==
          {1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0}) begin
        miscompares++;
        $display("FAIL lsu_req_stable[%0d]: got %h expected %h", i,
                 {mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask, ifu_rsp_valid},
                 {1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0});
      end
      step;
    end
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h5A5A_0000;
    #2;
    vectors++;
    if ({lsu_rsp_valid, lsu_rsp_data, ifu_rsp_valid, ifu_rsp_data, mem_rsp_ready} !==
        {1'b1, 32'h5A5A_0000, 1'b0, 32'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL lsu_ack: got %h expected %h",
               {lsu_rsp_valid, lsu_rsp_data, ifu_rsp_valid, ifu_rsp_data, mem_rsp_ready},
               {1'b1, 32'h5A5A_0000, 1'b0, 32'h0, 1'b1});
    end
    step;
    mem_rsp_valid = 1'b0; lsu_req_wen = 1'b0;
    #2;
    vectors++;
    if ({arb_busy, lsu_rsp_valid, ifu_rsp_valid} !== 3'b000) begin
      miscompares++; $display("FAIL lsu_done: got %b expected 000", {arb_busy, lsu_rsp_valid, ifu_rsp_valid});
    end
  endtask

  task automatic test_both_valid;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; ifu_rsp_ready = 1'b1; lsu_rsp_ready = 1'b1;
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    #2;
    vectors++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin
      miscompares++; $display("FAIL both_lsu_first: got %b expected 01", {ifu_req_ready, lsu_req_ready});
    end
    step;
    lsu_req_valid = 1'b0;
    #2;
    vectors++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin
      miscompares++; $display("FAIL both_busy: got %b expected 00", {ifu_req_ready, lsu_req_ready});
    end
    step; step;
    #2;
    vectors++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
      miscompares++; $display("FAIL both_ifu_next: got %b expected 10", {ifu_req_ready, lsu_req_ready});
    end
    step;
    ifu_req_valid = 1'b0;
    step; step;
    #2;
    vectors++;
    if (arb_busy !== 1'b0) begin
      miscompares++; $display("FAIL both_drained: got %b expected 0", arb_busy);
    end
  endtask

  task automatic test_streak;
    logic [9:0] ifu_turn;
    logic [1:0] exp_rdy;
    ifu_turn = 10'b10_0001_0000;
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    #2;
    for (int g = 0; g < 10; g++) begin
      exp_rdy = ifu_turn[g] ? 2'b10 : 2'b01;
      vectors++;
      if ({ifu_req_ready, lsu_req_ready} !== exp_rdy) begin
        miscompares++;
        $display("FAIL streak_grant[%0d]: got %b expected %b", g, {ifu_req_ready, lsu_req_ready}, exp_rdy);
      end
      step;
      if (g == 9) begin
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
      end
      #2;
      vectors++;
      if ({ifu_req_ready, lsu_req_ready, mem_req_valid} !== 3'b001) begin
        miscompares++;
        $display("FAIL streak_busy[%0d]: got %b expected 001", g, {ifu_req_ready, lsu_req_ready, mem_req_valid});
      end
      step; step;
      #2;
    end
  endtask

  task automatic test_rsp_backpressure;
    mem_rsp_valid = 1'b0; lsu_rsp_ready = 1'b0; ifu_rsp_ready = 1'b0; mem_req_ready = 1'b1;
    lsu_req_valid = 1'b1; lsu_req_wen = 1'b0;
    #2;
    vectors++;
    if (lsu_req_ready !== 1'b1) begin
      miscompares++; $display("FAIL bp_grant: got %b expected 1", lsu_req_ready);
    end
    step;
    lsu_req_valid = 1'b0; ifu_req_valid = 1'b1;
    step;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE_0001;
    for (int i = 0; i < 2; i++) begin
      #2;
      vectors++;
      if ({mem_rsp_ready, lsu_rsp_valid, lsu_rsp_data, ifu_rsp_valid, arb_busy, ifu_req_ready} !==
          {1'b0, 1'b1, 32'hCAFE_0001, 1'b0, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL bp_stall[%0d]: got %h expected %h", i,
                 {mem_rsp_ready, lsu_rsp_valid, lsu_rsp_data, ifu_rsp_valid, arb_busy, ifu_req_ready},
                 {1'b0, 1'b1, 32'hCAFE_0001, 1'b0, 1'b1, 1'b0});
      end
      step;
    end
    lsu_rsp_ready = 1'b1;
    #2;
    vectors++;
    if (mem_rsp_ready !== 1'b1) begin
      miscompares++; $display("FAIL bp_release: got %b expected 1", mem_rsp_ready);
    end
    step;
    mem_rsp_valid = 1'b0;
    #2;
    vectors++;
    if ({arb_busy, ifu_req_ready, lsu_req_ready} !== 3'b010) begin
      miscompares++;
      $display("FAIL bp_next_grant: got %b expected 010", {arb_busy, ifu_req_ready, lsu_req_ready});
    end
    step;
    ifu_req_valid = 1'b0; ifu_rsp_ready = 1'b1;
    step;
    mem_rsp_valid = 1'b1;
    step;
    mem_rsp_valid = 1'b0;
    #2;
    vectors++;
    if (arb_busy !== 1'b0) begin
      miscompares++; $display("FAIL bp_drained: got %b expected 0", arb_busy);
    end
  endtask

  initial begin
    test_reset();
    test_ifu_read();
    test_lsu_write();
    test_both_valid();
    test_streak();
    test_rsp_backpressure();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
